// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, buffers
// returned words in a 2-entry FIFO for IF/ID, and flushes on branch redirects.
module ifetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    input  logic        redir_en,
    input  logic [31:0] redir_pc,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FULL  = 2'd1,
        REDIR = 2'd2
    } stateType;

    stateType    state;
    logic [31:0] fpc;
    logic [1:0]  count;
    logic        inFlight;
    logic [31:0] inFlightPc;
    logic [31:0] headInst;
    logic [31:0] headPc;
    logic [31:0] tailInst;
    logic [31:0] tailPc;

    logic        pop;
    logic        push;
    logic        accept;
    logic        creditOk;
    logic [1:0]  afterPop;
    logic [2:0]  committed;
    logic [31:0] redirTarget;

    assign redirTarget = redir_pc & 32'hFFFF_FFFC;

    // A response arriving in a redirect cycle belongs to the old path and is discarded.
    assign pop       = (count != 2'd0) && id_ready;
    assign push      = inFlight && !redir_en;
    assign afterPop  = count - {1'b0, pop};
    assign committed = {1'b0, afterPop} + {2'b00, inFlight};
    assign creditOk  = (committed < 3'd2);

    assign imem_req   = !rst && !redir_en && (state != FULL) && creditOk;
    assign accept     = imem_req && imem_gnt;
    assign imem_addr  = fpc[13:2];
    assign inst_valid = (count != 2'd0);
    assign inst       = headInst;
    assign inst_pc    = headPc;

    // Control FSM, fetch PC, in-flight tracking and the two-entry return FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            fpc        <= 32'h0000_3000;
            count      <= 2'd0;
            inFlight   <= 1'b0;
            inFlightPc <= 32'h0;
            headInst   <= 32'h0;
            headPc     <= 32'h0;
            tailInst   <= 32'h0;
            tailPc     <= 32'h0;
        end else begin
            if (redir_en) begin
                state <= REDIR;
            end else begin
                case (state)
                    RUN:     if (!creditOk) state <= FULL;
                    FULL:    if (pop) state <= RUN;
                    REDIR:   state <= RUN;
                    default: state <= RUN;
                endcase
            end

            if (redir_en) begin
                fpc <= redirTarget;
            end else if (accept) begin
                fpc <= fpc + 32'd4;
            end

            inFlight <= accept;
            if (accept) begin
                inFlightPc <= fpc;
            end

            // The write slot is the first free entry after this cycle's pop shifts the tail forward.
            if (redir_en) begin
                count <= 2'd0;
            end else begin
                count <= count + {1'b0, push} - {1'b0, pop};
                if (pop) begin
                    headInst <= tailInst;
                    headPc   <= tailPc;
                end
                if (push) begin
                    if (afterPop == 2'd0) begin
                        headInst <= imem_rdata;
                        headPc   <= inFlightPc;
                    end else if (afterPop == 2'd1) begin
                        tailInst <= imem_rdata;
                        tailPc   <= inFlightPc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a one-cycle-latency memory that returns the
// word address as data, with hand-derived cycle-by-cycle expectations.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic        redir_en;
    logic [31:0] redir_pc;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rdata (imem_rdata),
        .redir_en   (redir_en),
        .redir_pc   (redir_pc),
        .id_ready   (id_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    // Memory answers an accepted request one cycle later with its word address.
    always @(posedge clk) begin
        if (imem_req && imem_gnt) imem_rdata <= {20'h0, imem_addr};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic g, input logic rdy,
                                 input logic re, input logic [31:0] rp);
        rst      = r;
        imem_gnt = g;
        id_ready = rdy;
        redir_en = re;
        redir_pc = rp;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
    endtask

    initial begin
        // Reset values, with grant and ready high to show the request is held off
        doReset();
        checkOutput("rst_req",   {31'h0, imem_req},   32'h0);
        checkOutput("rst_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("rst_inst",  inst,                32'h0);
        checkOutput("rst_pc",    inst_pc,             32'h0);
        checkOutput("rst_addr",  {20'h0, imem_addr},  32'h0000_0C00);

        // Streaming
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("str_c0_req",  {31'h0, imem_req},  32'h1);
        checkOutput("str_c0_addr", {20'h0, imem_addr}, 32'h0000_0C00);
        nextCycle();
        checkOutput("str_c1_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        checkOutput("str_c2_pc",   inst_pc, 32'h0000_3000);
        checkOutput("str_c2_inst", inst,    32'h0000_0C00);
        nextCycle();
        checkOutput("str_c3_pc",   inst_pc, 32'h0000_3004);
        checkOutput("str_c3_inst", inst,    32'h0000_0C01);
        nextCycle();
        checkOutput("str_c4_pc",   inst_pc, 32'h0000_3008);
        checkOutput("str_c4_inst", inst,    32'h0000_0C02);

        // Backpressure: id_ready low for five cycles
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("bp_c2_req", {31'h0, imem_req}, 32'h0);
        nextCycle();
        checkOutput("bp_c3_req", {31'h0, imem_req}, 32'h0);
        checkOutput("bp_c3_pc",  inst_pc,           32'h0000_3000);
        nextCycle();
        checkOutput("bp_c4_pc",    inst_pc,             32'h0000_3000);
        checkOutput("bp_c4_valid", {31'h0, inst_valid}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("bp_c5_pc",  inst_pc,           32'h0000_3000);
        checkOutput("bp_c5_req", {31'h0, imem_req}, 32'h0);
        nextCycle();
        checkOutput("bp_c6_pc", inst_pc, 32'h0000_3004);
        nextCycle();
        checkOutput("bp_c7_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        checkOutput("bp_c8_pc", inst_pc, 32'h0000_3008);

        // Mid-stream reset with two buffered entries
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("mr_full_valid", {31'h0, inst_valid}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mr_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("mr_pc",    inst_pc,             32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        checkOutput("mr_c1_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        checkOutput("mr_c2_pc", inst_pc, 32'h0000_3000);

        // Redirect while the 0x3008 response is arriving
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3043);
        checkOutput("rd_c3_req", {31'h0, imem_req}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rd_c4_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("rd_c4_req",   {31'h0, imem_req},   32'h1);
        checkOutput("rd_c4_addr",  {20'h0, imem_addr},  32'h0000_0C10);
        nextCycle();
        checkOutput("rd_c5_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        checkOutput("rd_c6_pc",   inst_pc, 32'h0000_3040);
        checkOutput("rd_c6_inst", inst,    32'h0000_0C10);
        nextCycle();
        checkOutput("rd_c7_pc", inst_pc, 32'h0000_3044);

        // Grant stall for three cycles
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("gs_c2_req",  {31'h0, imem_req},  32'h1);
        checkOutput("gs_c2_addr", {20'h0, imem_addr}, 32'h0000_0C02);
        nextCycle();
        checkOutput("gs_c3_addr", {20'h0, imem_addr}, 32'h0000_0C02);
        checkOutput("gs_c3_pc",   inst_pc,            32'h0000_3004);
        nextCycle();
        checkOutput("gs_c4_addr",  {20'h0, imem_addr},  32'h0000_0C02);
        checkOutput("gs_c4_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        checkOutput("gs_c6_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        checkOutput("gs_c7_pc", inst_pc, 32'h0000_3008);
        nextCycle();
        checkOutput("gs_c8_pc", inst_pc, 32'h0000_300C);

        // Back-to-back redirects, last target wins, then address wrap
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_5000);
        checkOutput("wr_c0_req", {31'h0, imem_req}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wr_c1_req",   {31'h0, imem_req},   32'h0);
        checkOutput("wr_c1_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wr_c2_req",  {31'h0, imem_req},  32'h1);
        checkOutput("wr_c2_addr", {20'h0, imem_addr}, 32'h0000_0FFF);
        nextCycle();
        checkOutput("wr_c3_valid", {31'h0, inst_valid}, 32'h0);
        nextCycle();
        checkOutput("wr_c4_pc",   inst_pc, 32'hFFFF_FFFC);
        checkOutput("wr_c4_inst", inst,    32'h0000_0FFF);
        nextCycle();
        checkOutput("wr_c5_pc",    inst_pc,             32'h0000_0000);
        checkOutput("wr_c5_valid", {31'h0, inst_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have ports `clk`, `rst`; single clock domain; `rst` is asynchronous and active-high.
REQ-002 `clk`  in  1  pipeline clock; all state updates on rising edge.
REQ-003 `rst`  in  1  asynchronous, active-high reset.
REQ-004 `imem_req`  out  1  fetch request to instruction memory.
REQ-005 `imem_addr`  out  12  word address; equals fetch PC[13:2].
REQ-006 `imem_gnt`  in  1  memory accepts the request this cycle (`imem_req` & `imem_gnt`).
REQ-007 `imem_rdata`  in  32  instruction word; valid exactly 1 cycle after acceptance.
REQ-008 `redir_en`  in  1  branch/jump redirect from the ID/EX stages.
REQ-009 `redir_pc`  in  32  redirect target; bits [1:0] ignored (forced 0).
REQ-010 `id_ready`  in  1  IF/ID register can load (driven from the hazard unit's IFID write enable).
REQ-011 `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction.
REQ-012 `inst`  out  32  instruction to IF/ID.
REQ-013 `inst_pc`  out  32  address of `inst`.

Function
REQ-014 SHALL keep a fetch PC register `fpc`; each accepted request advances `fpc` by 4 (modulo 2^32 wrap).
REQ-015 SHALL buffer returned instructions with their PCs in a 2-entry FIFO; head drives `inst`/`inst_pc`; `inst_valid` = FIFO non-empty.
REQ-016 SHALL pop the head when `inst_valid` & `id_ready`.
REQ-017 SHALL assert `imem_req` only if (FIFO occupancy + in-flight count) < 2 after this cycle's pop and `redir_en`=0; in-flight count is at most 1.
REQ-018 SHALL write the response into the FIFO in the cycle after acceptance unless marked dropped; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-019 FSM states: RUN (issuing allowed), FULL (occupancy + in-flight = 2, `imem_req`=0), REDIR (one-cycle flush).
REQ-020 Transitions: RUN->FULL when the credit check fails; FULL->RUN on pop; any state->REDIR on `redir_en`; REDIR->RUN unconditionally.
REQ-021 On `redir_en` the unit SHALL, at that edge: empty the FIFO, set `fpc` to {`redir_pc`[31:2],2'b00}, mark any in-flight response dropped, and deassert `imem_req` in that cycle.
REQ-022 `inst_valid` SHALL be 0 in the cycle after `redir_en`; the first fetch from the target SHALL issue in REDIR.
REQ-023 A `redir_en` coinciding with a pop SHALL take priority; the popped instruction is still consumed that cycle.
REQ-024 A `redir_en` coinciding with an arriving response SHALL discard that response.
REQ-025 A `redir_en` held for consecutive cycles SHALL apply each cycle's target; the last target wins.
REQ-026 `imem_req` deasserted while `imem_gnt`=0 with no acceptance SHALL be legal; `imem_addr` SHALL stay stable while `imem_req`=1 and `imem_gnt`=0.
REQ-027 Throughput: with `imem_gnt`=1, `id_ready`=1 and no redirect, one instruction per cycle after a 2-cycle initial latency from reset release.

Reset
REQ-028 On `rst`=1 (asynchronously): `fpc`=32'h0000_3000, FIFO empty, in-flight cleared, drop flag cleared, FSM=RUN.
REQ-029 During reset, outputs SHALL be `imem_req`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, and `imem_addr`=12'hC00.
REQ-030 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; no response arriving after release SHALL enter the FIFO unless requested after release.

Verification
REQ-031 Stream: release reset, `imem_gnt`=1, `id_ready`=1, memory returns the word address -> `inst_pc` = 0x3000, 0x3004, 0x3008 on consecutive cycles starting 2 cycles after release; `inst` = 0xC00, 0xC01, 0xC02.
REQ-032 Backpressure: `id_ready`=0 for 5 cycles -> FIFO fills to 2, `imem_req`=0, and `inst_pc` holds 0x3000; after release, 0x3000 and 0x3004 are delivered without loss or duplication.
REQ-033 Redirect with in-flight fetch: `redir_en`=1 with `redir_pc`=0x3043 while the 0x3008 response is pending -> 0x3008 is never presented; the next `inst_pc` is 0x3040.
REQ-034 Grant stall: `imem_gnt`=0 for 3 cycles -> `imem_addr` stays constant and `inst_valid` drops once the FIFO drains; sequential order resumes after the grant.
REQ-035 Mid-stream reset: assert `rst` for 1 cycle while 2 entries are buffered -> `inst_valid`=0 immediately; after release the first `inst_pc` is 0x3000.
REQ-036 Wrap: `redir_pc`=0xFFFF_FFFC -> delivered `inst_pc` sequence is 0xFFFF_FFFC, then 0x0000_0000.
